// File: rtl/pipe_ctrl_p.sv
// pipe_ctrl_p: 4-stage IF/ID/EX/WB pipeline control with stall, branch flush, forwarding and retire count
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   instr, instr_valid   : fetched instruction and its qualifier
//   stall                : hold IF/ID and ID/EX, bubble into EX/WB
//   instr_ready          : fetch may advance (~stall)
//   flush                : squash the fetch presented this cycle (branch shadow)
//   *_instr / *_valid    : per-stage instruction and valid
//   *_pc_src/_alu/_reg_wrt : per-stage decoded controls
//   fwd_sel              : forward EX/WB result to the ID/EX rs operand
//   retire_cnt           : wrapping count of instructions leaving EX/WB
module pipe_ctrl_p #(
    parameter int INSTR_W = 8,
    parameter int RA      = 3,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               stall,
    output logic               instr_ready,
    output logic               flush,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] id_ex_instr,
    output logic [INSTR_W-1:0] ex_wb_instr,
    output logic               if_id_valid,
    output logic               id_ex_valid,
    output logic               ex_wb_valid,
    output logic               if_id_pc_src,
    output logic               if_id_alu,
    output logic               id_ex_alu,
    output logic               if_id_reg_wrt,
    output logic               id_ex_reg_wrt,
    output logic               ex_wb_reg_wrt,
    output logic               fwd_sel,
    output logic [CNT_W-1:0]   retire_cnt
);
    logic take;
    assign instr_ready = ~stall;
    // stall wins over a pending branch: the branch holds and flush fires once stall drops
    assign flush = if_id_valid & if_id_pc_src & ~stall;
    assign take  = instr_valid & ~flush;
    assign fwd_sel = (FWD_EN != 0) && id_ex_valid && ex_wb_valid && ex_wb_reg_wrt &&
                     (id_ex_instr[RA-1:0] == ex_wb_instr[2*RA-1:RA]);
    // a squashed or absent fetch loads a bubble with every control cleared
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            if_id_valid   <= 1'b0;
            if_id_instr   <= '0;
            if_id_pc_src  <= 1'b0;
            if_id_alu     <= 1'b0;
            if_id_reg_wrt <= 1'b0;
        end else if (!stall) begin
            if_id_valid   <= take;
            if_id_instr   <= take ? instr : '0;
            if_id_pc_src  <= take & instr[INSTR_W-1];
            if_id_alu     <= take & instr[INSTR_W-2];
            if_id_reg_wrt <= take & ~instr[INSTR_W-1];
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            id_ex_valid   <= 1'b0;
            id_ex_instr   <= '0;
            id_ex_alu     <= 1'b0;
            id_ex_reg_wrt <= 1'b0;
        end else if (!stall) begin
            id_ex_valid   <= if_id_valid;
            id_ex_instr   <= if_id_instr;
            id_ex_alu     <= if_id_alu;
            id_ex_reg_wrt <= if_id_reg_wrt;
        end
    // EX/WB never holds: during a stall it drains into a bubble so nothing is duplicated
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ex_wb_valid   <= 1'b0;
            ex_wb_instr   <= '0;
            ex_wb_reg_wrt <= 1'b0;
        end else begin
            ex_wb_valid   <= ~stall & id_ex_valid;
            ex_wb_instr   <= stall ? '0 : id_ex_instr;
            ex_wb_reg_wrt <= ~stall & id_ex_reg_wrt;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            retire_cnt <= '0;
        else if (ex_wb_valid)
            retire_cnt <= retire_cnt + CNT_W'(1);
endmodule

// File: tb/tb_pipe_ctrl_p.sv
// tb_pipe_ctrl_p: directed-vector bench for pipe_ctrl_p (main instance plus a FWD_EN=0, 4-bit counter instance)
module tb_pipe_ctrl_p;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic       instr_ready, flush, if_id_valid, id_ex_valid, ex_wb_valid;
    logic       if_id_pc_src, if_id_alu, id_ex_alu, if_id_reg_wrt, id_ex_reg_wrt, ex_wb_reg_wrt, fwd_sel;
    logic [7:0] if_id_instr, id_ex_instr, ex_wb_instr;
    logic [15:0] retire_cnt;
    logic       d2_ready, d2_flush, d2_if_v, d2_id_v, d2_ex_v, d2_pc, d2_if_alu, d2_id_alu;
    logic       d2_if_rw, d2_id_rw, d2_ex_rw, d2_fwd;
    logic [7:0] d2_if_i, d2_id_i, d2_ex_i;
    logic [3:0] d2_cnt;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       saw_05 = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_p dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .instr_ready(instr_ready), .flush(flush),
        .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr), .ex_wb_instr(ex_wb_instr),
        .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid), .ex_wb_valid(ex_wb_valid),
        .if_id_pc_src(if_id_pc_src), .if_id_alu(if_id_alu), .id_ex_alu(id_ex_alu),
        .if_id_reg_wrt(if_id_reg_wrt), .id_ex_reg_wrt(id_ex_reg_wrt), .ex_wb_reg_wrt(ex_wb_reg_wrt),
        .fwd_sel(fwd_sel), .retire_cnt(retire_cnt)
    );

    pipe_ctrl_p #(.FWD_EN(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .instr_ready(d2_ready), .flush(d2_flush),
        .if_id_instr(d2_if_i), .id_ex_instr(d2_id_i), .ex_wb_instr(d2_ex_i),
        .if_id_valid(d2_if_v), .id_ex_valid(d2_id_v), .ex_wb_valid(d2_ex_v),
        .if_id_pc_src(d2_pc), .if_id_alu(d2_if_alu), .id_ex_alu(d2_id_alu),
        .if_id_reg_wrt(d2_if_rw), .id_ex_reg_wrt(d2_id_rw), .ex_wb_reg_wrt(d2_ex_rw),
        .fwd_sel(d2_fwd), .retire_cnt(d2_cnt)
    );

    always @(negedge clk)
        if (if_id_instr == 8'h05 || id_ex_instr == 8'h05 || ex_wb_instr == 8'h05) saw_05 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_id"}, {if_id_valid, if_id_instr, if_id_pc_src, if_id_alu, if_id_reg_wrt}, 0);
        chk({tag, "_id_ex"}, {id_ex_valid, id_ex_instr, id_ex_alu, id_ex_reg_wrt}, 0);
        chk({tag, "_ex_wb"}, {ex_wb_valid, ex_wb_instr, ex_wb_reg_wrt}, 0);
        chk({tag, "_cnt"}, retire_cnt, 0);
        chk({tag, "_flush_fwd"}, {flush, fwd_sel}, 0);
        chk({tag, "_ready"}, instr_ready, 1);
    endtask

    initial begin
        #2;
        chk_zero("rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        // stream 0x01, 0x42, 0x13
        instr = 8'h01; instr_valid = 1'b1;
        cyc();
        chk("s1_if_id", {if_id_valid, if_id_instr, if_id_alu, if_id_reg_wrt, if_id_pc_src}, {1'b1, 8'h01, 1'b0, 1'b1, 1'b0});
        instr = 8'h42;
        cyc();
        chk("s2_if_id", {if_id_instr, if_id_alu}, {8'h42, 1'b1});
        chk("s2_id_ex", id_ex_instr, 8'h01);
        instr = 8'h13;
        cyc();
        chk("s3_id_ex", {id_ex_valid, id_ex_instr, id_ex_alu, id_ex_reg_wrt}, {1'b1, 8'h42, 1'b1, 1'b1});
        chk("s3_ex_wb", ex_wb_instr, 8'h01);
        chk("s3_fwd_nomatch", fwd_sel, 0);
        instr_valid = 1'b0;
        cyc();
        chk("s4_ex_wb", {ex_wb_valid, ex_wb_instr, ex_wb_reg_wrt}, {1'b1, 8'h42, 1'b1});
        chk("s4_cnt", retire_cnt, 1);
        cyc();
        chk("s5_ex_wb", ex_wb_instr, 8'h13);
        cyc();
        cyc();
        chk("s_cnt_final", retire_cnt, 3);
        // branch 0x80 followed by 0x05
        instr = 8'h80; instr_valid = 1'b1;
        cyc();
        chk("b_if_id", {if_id_valid, if_id_pc_src, if_id_reg_wrt}, {1'b1, 1'b1, 1'b0});
        instr = 8'h05;
        #1;
        chk("b_flush", flush, 1);
        cyc();
        instr_valid = 1'b0;
        chk("b_shadow", {if_id_valid, if_id_instr}, 0);
        chk("b_id_ex", {id_ex_instr, id_ex_reg_wrt}, {8'h80, 1'b0});
        chk("b_flush_off", flush, 0);
        cyc();
        chk("b_ex_wb", {ex_wb_valid, ex_wb_instr, ex_wb_reg_wrt}, {1'b1, 8'h80, 1'b0});
        cyc();
        cyc();
        chk("b_cnt", retire_cnt, 4);
        chk("b_no_05", saw_05, 0);
        // stall with 0x11 in IF/ID and 0x22 in ID/EX
        instr = 8'h22; instr_valid = 1'b1;
        cyc();
        instr = 8'h11;
        cyc();
        instr = 8'h33; stall = 1'b1;
        #1;
        chk("st_ready", instr_ready, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("st_hold", {if_id_instr, id_ex_instr}, {8'h11, 8'h22});
            chk("st_bubble", {ex_wb_valid, ex_wb_instr}, 0);
        end
        stall = 1'b0;
        cyc();
        instr_valid = 1'b0;
        chk("st_r1", {ex_wb_valid, ex_wb_instr, id_ex_instr, if_id_instr}, {1'b1, 8'h22, 8'h11, 8'h33});
        cyc();
        chk("st_r2", ex_wb_instr, 8'h11);
        cyc();
        chk("st_r3", ex_wb_instr, 8'h33);
        cyc();
        chk("st_cnt", retire_cnt, 7);
        // stall and branch together
        instr = 8'h80; instr_valid = 1'b1;
        cyc();
        instr = 8'h06; stall = 1'b1;
        #1;
        chk("sb_flush0", flush, 0);
        cyc();
        chk("sb_hold", {if_id_instr, flush}, {8'h80, 1'b0});
        stall = 1'b0;
        #1;
        chk("sb_flush1", flush, 1);
        cyc();
        instr_valid = 1'b0;
        chk("sb_squash", {if_id_valid, id_ex_instr}, {1'b0, 8'h80});
        cyc();
        cyc();
        // forwarding 0x18 (rd=3) then 0x03 (rs=3)
        instr = 8'h18; instr_valid = 1'b1;
        cyc();
        instr = 8'h03;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk("f_stages", {id_ex_instr, ex_wb_instr}, {8'h03, 8'h18});
        chk("f_sel", fwd_sel, 1);
        chk("f_sel_dis", d2_fwd, 0);
        cyc();
        chk("f_sel_gone", fwd_sel, 0);
        instr = 8'h98; instr_valid = 1'b1;
        cyc();
        instr = 8'h03;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk("f_branch", {ex_wb_instr, ex_wb_reg_wrt, fwd_sel}, {8'h98, 1'b0, 1'b0});
        // asynchronous reset mid-stream
        instr = 8'h41; instr_valid = 1'b1;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        instr_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        // counter wrap on the 4-bit instance: 16 retirements
        instr = 8'h01; instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) cyc();
        instr_valid = 1'b0;
        cyc();
        cyc();
        chk("w_cnt15", d2_cnt, 15);
        cyc();
        chk("w_wrap", d2_cnt, 0);
        chk("w_cnt16", retire_cnt, 16);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_p.md
# pipe_ctrl_p

Parametrised 4-stage pipeline control for the MIPS-style core: the successor to the fixed 8-bit IF/ID/EX/WB control shift chain. It registers the fetched instruction and its decoded controls (pc_src, alu, reg_wrt) through IF/ID, ID/EX and EX/WB. It adds per-stage valid bits, a stall that holds the front of the pipe and injects bubbles, branch-shadow flush, EX/WB→ID/EX forwarding detection and a retired-instruction counter. It sits between instruction fetch and the datapath register-file/ALU muxes.

## Interface
- INSTR_W, 8: instruction width; must satisfy INSTR_W ≥ 2*RA+2.
- RA, 3: register-address field width.
- FWD_EN, 1: 1 enables fwd_sel generation; 0 ties fwd_sel to 0.
- CNT_W, 16: retire counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  fetched instruction.
- instr_valid  in  1  instr holds a real instruction.
- stall  in  1  datapath hazard hold request.
- instr_ready  out  1  fetch may advance. Equals ~stall (combinational).
- flush  out  1  squash the fetch currently presented (combinational).
- if_id_instr / id_ex_instr / ex_wb_instr  out  INSTR_W  stage instruction registers.
- if_id_valid / id_ex_valid / ex_wb_valid  out  1  stage valid.
- if_id_pc_src  out  1  branch in IF/ID.
- if_id_alu / id_ex_alu  out  1  ALU-op control.
- if_id_reg_wrt / id_ex_reg_wrt / ex_wb_reg_wrt  out  1  register write enable.
- fwd_sel  out  1  forward EX/WB result to the ID/EX rs operand (combinational).
- retire_cnt  out  CNT_W  count of instructions leaving EX/WB.

## Operation
- Field decode: pc_src = instr[INSTR_W-1]; alu = instr[INSTR_W-2]; reg_wrt = ~instr[INSTR_W-1]; rd = instr[2*RA-1:RA]; rs = instr[RA-1:0].
- Bubble: valid=0, instr=0, all controls=0. Every control of a bubble is 0, including reg_wrt.
- Normal advance (stall=0):
  - IF/ID loads the decoded instr when instr_valid=1 and flush=0. Otherwise it loads a bubble.
  - ID/EX loads IF/ID.
  - EX/WB loads ID/EX.
- Stall (stall=1):
  - IF/ID and ID/EX hold their contents.
  - EX/WB loads a bubble.
  - instr is not consumed.
- Flush: flush = if_id_valid & if_id_pc_src & ~stall. The branch itself advances normally. The instruction presented in the same cycle is replaced by a bubble, so there is one shadow slot.
- Stall and branch together: stall wins. flush stays 0 and the branch holds in IF/ID. flush asserts in the first non-stall cycle.
- Forwarding: fwd_sel = FWD_EN & id_ex_valid & ex_wb_valid & ex_wb_reg_wrt & (id_ex rs == ex_wb rd).
- Retire: retire_cnt increments on every edge where ex_wb_valid=1. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: all stage registers, valids, controls and retire_cnt are 0 immediately on rst_n low. This holds even mid-operation, and in-flight instructions are lost. instr_ready follows stall. flush and fwd_sel are 0 because every valid is 0.
- Latency: an instruction accepted at edge N is in IF/ID after N, ID/EX after N+1 and EX/WB after N+2. retire_cnt reflects it after N+3.
- Throughput: one instruction per cycle with no stall and no branch.
- Stall of k cycles inserts exactly k EX/WB bubbles. No instruction is lost or duplicated.
- flush, fwd_sel and instr_ready are combinational from registers and stall. There are no registered handshakes.

## Test plan
- Reset then stream 0x01,0x42,0x13 with valid=1, no stall:
  - 0x42 appears in EX/WB two edges after acceptance with ex_wb_alu path set and reg_wrt=1.
  - retire_cnt=3 after the last edge.
- Branch 0x80 followed by 0x05:
  - flush=1 in the cycle 0x80 sits in IF/ID.
  - 0x05 never appears in any stage.
  - id_ex_reg_wrt=0 for the branch.
  - retire_cnt increments by 1 only.
- stall=1 for 2 cycles with 0x11 in IF/ID and 0x22 in ID/EX:
  - both hold.
  - ex_wb_valid=0 for 2 cycles.
  - 0x22 then retires, followed by 0x11.
- Stall and branch together: branch in IF/ID, stall=1.
  - flush=0 while stalled.
  - flush=1 in the first cycle after stall drops.
- Forwarding, sequence 0x18 (rd=3) then 0x03 (rs=3):
  - fwd_sel=1 when 0x03 is in ID/EX and 0x18 is in EX/WB.
  - With FWD_EN=0, fwd_sel=0.
  - A branch with matching rd gives fwd_sel=0.
- Assert rst_n low mid-stream: all outputs 0 immediately. Also preload retire_cnt to 0xFFFF and retire one instruction: retire_cnt wraps to 0.
